// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks destination registers in flight after ID, stalls decode on a
// source match, counts stall cycles and cross-checks each retiring entry against the WB write port.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 4,
   parameter int PIPE_DEPTH = 3,
   parameter bit FORWARD_EN = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  has_two_src,
   input  logic                  id_wb_enable,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] id_dest_reg,
   input  logic                  flush,
   input  logic                  freeze,
   input  logic                  reg_file_wb_en,
   input  logic [REG_ADDR_W-1:0] reg_file_wb_address,
   output logic                  hazard_detected,
   output logic [CNT_W-1:0]      stall_count,
   output logic                  sb_mismatch
);

   // WB is never compared: the register file writes before it reads in the same cycle.
   localparam int HZ_STAGES = PIPE_DEPTH - 1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [PIPE_DEPTH-1:0] v_q;
   logic [REG_ADDR_W-1:0] dst_q [PIPE_DEPTH];
   // The load flag is only ever consulted in EXE, so deeper stages do not carry it.
   logic                  ld0_q;

   logic [HZ_STAGES-1:0]  m1;
   logic [HZ_STAGES-1:0]  m2;
   logic                  match_any;
   logic                  match_load;
   logic                  retire_bad;

   always_comb begin
      m1 = '0;
      m2 = '0;
      for (int k = 0; k < HZ_STAGES; k++) begin
         m1[k] = v_q[k] && (dst_q[k] == src1);
         m2[k] = v_q[k] && has_two_src && (dst_q[k] == src2);
      end
   end

   assign match_any       = |(m1 | m2);
   assign match_load      = (m1[0] | m2[0]) & ld0_q;
   assign hazard_detected = !flush && (FORWARD_EN ? match_load : match_any);

   assign retire_bad = (v_q[PIPE_DEPTH-1] != reg_file_wb_en) ||
                       (v_q[PIPE_DEPTH-1] && reg_file_wb_en &&
                        (dst_q[PIPE_DEPTH-1] != reg_file_wb_address));

   always_ff @(posedge clk) begin
      if (!rst) begin
         v_q         <= '0;
         ld0_q       <= 1'b0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            dst_q[k] <= '0;
         end
         stall_count <= '0;
         sb_mismatch <= 1'b0;
      end else if (!freeze) begin
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            v_q[k]   <= v_q[k-1];
            dst_q[k] <= dst_q[k-1];
         end
         if (flush || hazard_detected) begin
            v_q[0]   <= 1'b0;
            ld0_q    <= 1'b0;
            dst_q[0] <= '0;
         end else begin
            v_q[0]   <= id_wb_enable;
            ld0_q    <= id_mem_read;
            dst_q[0] <= id_dest_reg;
         end
         if (hazard_detected && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_ONE;
         end
         if (retire_bad) begin
            sb_mismatch <= 1'b1;
         end
      end
   end

endmodule
